// File: rtl/combo_sweeper.sv
// Exhaustive combinational sweeper: walks every input vector into an external
// device, holds each for HOLD cycles, captures the response and scores it against an expected table.
module combo_sweeper #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2,
  parameter int HOLD  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_OUT-1:0] dut_out,
  input  logic             exp_we,
  input  logic [N_IN-1:0]  exp_addr,
  input  logic [N_OUT-1:0] exp_data,
  input  logic [N_IN-1:0]  rd_addr,
  output logic [N_IN-1:0]  vec,
  output logic             busy,
  output logic             done,
  output logic [N_OUT-1:0] rd_data,
  output logic [N_IN:0]    err_cnt,
  output logic             first_err_valid,
  output logic [N_IN-1:0]  first_err_addr
);

  localparam int              DEPTH     = 1 << N_IN;
  localparam int              HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = {N_IN{1'b1}};

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state, state_next;
  logic [HW-1:0]    hold_cnt;
  logic             launch, sample, mismatch;
  logic [N_OUT-1:0] exp_mem [DEPTH];
  logic [N_OUT-1:0] cap_mem [DEPTH];

  // NOTE: clocked state uses non-blocking assignments so every register
  // updates from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    sample     = 1'b0;
    busy       = (state == ST_RUN);
    done       = (state == ST_DONE);
    unique case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_next = ST_RUN;
          launch     = 1'b1;
        end
      end
      ST_RUN: begin
        // abort beats the sample, so the vector in flight is never scored
        if (abort) begin
          state_next = ST_IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          sample = 1'b1;
          if (vec == VEC_LAST) state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign mismatch = (dut_out != exp_mem[vec]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec             <= '0;
      hold_cnt        <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
    end else if (launch) begin
      vec             <= '0;
      hold_cnt        <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
    end else if (state == ST_RUN) begin
      if (abort) begin
        vec      <= '0;
        hold_cnt <= '0;
      end else if (sample) begin
        // the increment wraps the last vector back to 0 on the way into DONE
        vec      <= vec + 1'b1;
        hold_cnt <= '0;
        if (mismatch) begin
          err_cnt <= err_cnt + 1'b1;
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_addr  <= vec;
          end
        end
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  // NOTE: the tables are plain storage with no reset, so they sit in a
  // clock-only process and can map onto RAM or register-file cells.
  always_ff @(posedge clk) begin
    if (exp_we && state == ST_IDLE) exp_mem[exp_addr] <= exp_data;
    if (sample)                     cap_mem[vec]      <= dut_out;
  end

  assign rd_data = cap_mem[rd_addr];

endmodule

// File: doc/combo_sweeper.md
COMBO_SWEEPER -- requirements
Module: combo_sweeper

Interface
REQ-001 Parameter: N_IN, default 3, number of stimulus bits driven to the device under test (1..8).
REQ-002 Parameter: N_OUT, default 2, number of response bits sampled from the device under test (1..16).
REQ-003 Parameter: HOLD, default 10, clock cycles each vector is held (>=1).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  one-cycle request to begin a full sweep.
REQ-007 abort  input  1  terminates a running sweep.
REQ-008 dut_out  input  N_OUT  response of the device under test to vec.
REQ-009 exp_we  input  1  write enable, expected-response table.
REQ-010 exp_addr  input  N_IN  expected-table write address (vector index).
REQ-011 exp_data  input  N_OUT  expected response for exp_addr.
REQ-012 rd_addr  input  N_IN  capture-table read address.
REQ-013 vec  output  N_IN  stimulus vector to the device under test.
REQ-014 busy  output  1  high while a sweep is running.
REQ-015 done  output  1  one-cycle pulse on sweep completion.
REQ-016 rd_data  output  N_OUT  captured response at rd_addr, combinational read.
REQ-017 err_cnt  output  N_IN+1  count of mismatching vectors in the last or current sweep.
REQ-018 first_err_valid / first_err_addr  output  1 / N_IN  a mismatch occurred; index of the first one.

Function
REQ-019 FSM states IDLE, RUN, DONE; IDLE->RUN on start&!abort; RUN->IDLE on abort; RUN->DONE after last sample; DONE->IDLE unconditionally after one cycle.
REQ-020 On IDLE->RUN edge: vec<=0, hold counter<=0, err_cnt<=0, first_err_valid<=0, first_err_addr<=0; busy high from the next cycle.
REQ-021 In RUN, each vector held exactly HOLD cycles; dut_out sampled on the HOLD-th cycle of that vector (hold counter == HOLD-1).
REQ-022 At sample: capture[vec]<=dut_out; if dut_out != expected[vec], err_cnt increments; first_err_addr<=vec and first_err_valid<=1 only if first_err_valid was 0.
REQ-023 After sampling vector v < 2^N_IN-1: vec<=v+1, hold counter<=0; after sampling 2^N_IN-1: enter DONE, vec returns to 0.
REQ-024 Full sweep: busy high exactly 2^N_IN*HOLD cycles; done high one cycle, the cycle after busy falls; busy and done never high together.
REQ-025 start while busy or in DONE is ignored; start and abort same cycle in IDLE: abort wins, stays IDLE.
REQ-026 abort in RUN: next cycle IDLE, busy=0, vec=0, done never asserted; err_cnt, first_err_* and captures already written retained; current vector not sampled.
REQ-027 exp_we honoured only while busy=0; writes during RUN/DONE dropped.
REQ-028 err_cnt saturates impossible by width (max 2^N_IN fits N_IN+1 bits); no wrap.
REQ-029 rd_data valid for any address written in a completed or aborted sweep; reads allowed at any time.

Reset
REQ-030 rst_n low: state IDLE, vec=0, busy=0, done=0, err_cnt=0, first_err_valid=0, first_err_addr=0, hold counter=0, immediately and independent of clk.
REQ-031 Expected and capture tables are not reset; contents undefined until written.
REQ-032 Reset mid-sweep aborts without done; first start after rst_n release begins a fresh sweep at vec=0.

Verification (N_IN=3, N_OUT=2, HOLD=10 unless stated)
REQ-033 Load expected = {a&b, a|c} for all 8 vectors, dut_out driven matching, start -> busy 80 cycles, vec steps 0..7 every 10 cycles, done one pulse, err_cnt=0, rd_data at 0..7 equals expected.
REQ-034 Same but dut_out forced wrong at vec 3 and 6 -> err_cnt=2, first_err_valid=1, first_err_addr=3.
REQ-035 abort on cycle 35 of sweep -> busy=0 next cycle, done never high, vec=0, captures 0..2 valid.
REQ-036 start pulsed again at cycle 20 of sweep, and exp_we during sweep -> no restart, expected table unchanged, sweep completes at 80 cycles.
REQ-037 rst_n low asynchronously mid-sweep -> busy=0, err_cnt=0 before next clk edge; subsequent start gives full 80-cycle sweep.
REQ-038 HOLD=1, N_IN=2: start -> busy exactly 4 cycles, vec 0,1,2,3 consecutive, done in cycle 5.
